traffic_phase_scheduler: RTL and testbench

//   Cycle-timed phase sequencer for the highway/side-road junction. Replaces

---
 rtl/traffic_phase_scheduler.sv | 106 ++++++++++
 tb/tb_traffic_phase_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Highway / side-road junction phase sequencer.
// Each phase dwells a fixed number of cycles, counted by an explicit counter.
// A latched pedestrian request inserts a walk phase after the highway all-red.
// Lamp outputs are a pure Moore decode of the registered state.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_SIDE  = 16,
    parameter int AMBER     = 5,
    parameter int ALLRED    = 3,
    parameter int WALK      = 6,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] hw,
    output logic [1:0] sw,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HA  = 3'd1,
        S_R1  = 3'd2,
        S_SG  = 3'd3,
        S_SA  = 3'd4,
        S_R2  = 3'd5,
        S_PW  = 3'd6,
        S_BAD = 3'd7
    } state_t;

    // A dwell of N cycles ends on the edge where the counter reads N-1.
    localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MS_LAST  = CNT_W'(MAX_SIDE - 1);
    localparam logic [CNT_W-1:0] AM_LAST  = CNT_W'(AMBER - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED - 1);
    localparam logic [CNT_W-1:0] WK_LAST  = CNT_W'(WALK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ped_pend_reg, ped_pend_next;

    // State, dwell counter and pedestrian latch registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg    <= S_HG;
            cnt_reg      <= '0;
            ped_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ped_pend_reg <= ped_pend_next;
        end
    end

    // Next-state, counter and pedestrian-latch update.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HG: if (cnt_reg >= MG_LAST && (side_req || ped_pend_reg)) state_next = S_HA;
            S_HA: if (cnt_reg == AM_LAST) state_next = S_R1;
            S_R1: if (cnt_reg == AR_LAST) state_next = ped_pend_reg ? S_PW : S_SG;
            S_PW: if (cnt_reg == WK_LAST) state_next = side_req ? S_SG : S_R2;
            // The MAX_SIDE exit is forced even while side_req is still high.
            S_SG: if ((cnt_reg >= MG_LAST && !side_req) || cnt_reg == MS_LAST) state_next = S_SA;
            S_SA: if (cnt_reg == AM_LAST) state_next = S_R2;
            S_R2: if (cnt_reg == AR_LAST) state_next = S_HG;
            default: state_next = S_HG;
        endcase

        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        // Entering the walk phase serves the request; a same-edge press is absorbed.
        if (state_next == S_PW && state_reg != S_PW) begin
            ped_pend_next = 1'b0;
        end else begin
            ped_pend_next = ped_pend_reg | ped_req;
        end
    end

    // Lamp decode from the state register only.
    always_comb begin
        hw    = 2'd0;
        sw    = 2'd0;
        walk  = 1'b0;
        phase = state_reg;
        case (state_reg)
            S_HG:    hw = 2'd2;
            S_HA:    hw = 2'd1;
            S_SG:    sw = 2'd2;
            S_SA:    sw = 2'd1;
            S_PW:    walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: table-driven phase sequences,
// hand-placed corner cases, then randomized traffic against a reference model.
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN = 8;
    localparam int MAX_SIDE  = 16;
    localparam int AMBER     = 5;
    localparam int ALLRED    = 3;
    localparam int WALK      = 6;

    localparam logic [2:0] P_HG = 3'd0, P_HA = 3'd1, P_R1 = 3'd2, P_SG = 3'd3,
                           P_SA = 3'd4, P_R2 = 3'd5, P_PW = 3'd6;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hw, sw;
    logic       walk;
    logic [2:0] phase;

    int tests  = 0;
    int failed = 0;

    traffic_phase_scheduler dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .side_req (side_req),
        .ped_req  (ped_req),
        .hw       (hw),
        .sw       (sw),
        .walk     (walk),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // One record: optionally reset, else hold inputs for n edges expecting phase ph after each.
    typedef struct {
        bit         rst;
        bit         side;
        bit         ped;
        int         n;
        logic [2:0] ph;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: phase, cycles already spent in it, pending walk request.
    int m_ph;
    int m_el;
    bit m_pend;

    function automatic logic [1:0] exp_hw(logic [2:0] ph);
        return (ph == P_HG) ? 2'd2 : (ph == P_HA) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] exp_sw(logic [2:0] ph);
        return (ph == P_SG) ? 2'd2 : (ph == P_SA) ? 2'd1 : 2'd0;
    endfunction

    function automatic int dwell(int ph);
        case (ph)
            1, 4:    return AMBER;
            2, 5:    return ALLRED;
            6:       return WALK;
            default: return 0;
        endcase
    endfunction

    function automatic void add(bit rst, bit side, bit ped, int n, logic [2:0] ph);
        vec_t v;
        v.rst = rst; v.side = side; v.ped = ped; v.n = n; v.ph = ph;
        vecs.push_back(v);
    endfunction

    task automatic check_out(string tag, logic [2:0] ph);
        logic [1:0] ehw, esw;
        logic       ewk;
        ehw = exp_hw(ph);
        esw = exp_sw(ph);
        ewk = (ph == P_PW);
        tests++;
        if (phase !== ph || hw !== ehw || sw !== esw || walk !== ewk) begin
            failed++;
            $display("FAIL %s: got phase=%0d hw=%0d sw=%0d walk=%0d, want phase=%0d hw=%0d sw=%0d walk=%0d",
                     tag, phase, hw, sw, walk, ph, ehw, esw, ewk);
        end
    endtask

    // Assert reset away from any edge, check outputs with no clock, release on a falling edge.
    task automatic do_reset();
        clr_n = 1'b0;
        #2;
        check_out("reset", P_HG);
        side_req = 1'b0;
        ped_req  = 1'b0;
        @(negedge clk);
        clr_n  = 1'b1;
        m_ph   = 0;
        m_el   = 0;
        m_pend = 1'b0;
    endtask

    task automatic step(bit s, bit p);
        side_req = s;
        ped_req  = p;
        @(posedge clk);
        #1;
    endtask

    // Advance the reference model by one clock edge using the phase rules.
    task automatic model_step(bit s, bit p);
        int  nxt;
        int  t;
        bit  done;
        nxt  = m_ph;
        t    = m_el + 1;
        done = (t >= dwell(m_ph));
        case (m_ph)
            0: if (t >= MIN_GREEN && (s || m_pend)) nxt = 1;
            1: if (done) nxt = 2;
            2: if (done) nxt = m_pend ? 6 : 3;
            6: if (done) nxt = s ? 3 : 5;
            3: if ((t >= MIN_GREEN && !s) || t == MAX_SIDE) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 6 && m_ph != 6) m_pend = 1'b0;
        else                        m_pend = m_pend | p;
        m_el = (nxt != m_ph) ? 0 : m_el + 1;
        m_ph = nxt;
    endtask

    // Lamp safety checks on every falling edge.
    always @(negedge clk) begin
        tests++;
        if ((hw != 2'd0 && sw != 2'd0) || (walk && (hw != 2'd0 || sw != 2'd0))) begin
            failed++;
            $display("FAIL safety: got hw=%0d sw=%0d walk=%0d, want no conflicting lamps", hw, sw, walk);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s_cur;
        bit p_now;

        // Full cycle with side_req held: MAX_SIDE forced exit.
        add(1, 0, 0, 0, P_HG);
        add(0, 1, 0, 7, P_HG);  add(0, 1, 0, 5, P_HA);  add(0, 1, 0, 3, P_R1);
        add(0, 1, 0, 16, P_SG); add(0, 1, 0, 5, P_SA);  add(0, 1, 0, 3, P_R2);
        add(0, 1, 0, 8, P_HG);  add(0, 1, 0, 1, P_HA);
        // Short side pulse before min green: stays highway green.
        add(1, 0, 0, 0, P_HG);
        add(0, 0, 0, 3, P_HG);  add(0, 1, 0, 1, P_HG);  add(0, 0, 0, 20, P_HG);
        // Pedestrian pulse at cnt=10, second press absorbed on PW entry.
        add(1, 0, 0, 0, P_HG);
        add(0, 0, 0, 10, P_HG); add(0, 0, 1, 1, P_HG);  add(0, 0, 0, 5, P_HA);
        add(0, 0, 0, 3, P_R1);  add(0, 0, 1, 1, P_PW);  add(0, 0, 0, 5, P_PW);
        add(0, 0, 0, 3, P_R2);  add(0, 0, 0, 12, P_HG);
        // Side request drops at SG cnt=2: SG still holds minimum green.
        add(1, 0, 0, 0, P_HG);
        add(0, 1, 0, 7, P_HG);  add(0, 1, 0, 5, P_HA);  add(0, 1, 0, 3, P_R1);
        add(0, 1, 0, 3, P_SG);  add(0, 0, 0, 5, P_SG);  add(0, 0, 0, 5, P_SA);
        add(0, 0, 0, 3, P_R2);  add(0, 0, 0, 3, P_HG);
        // Reset mid-SA at cnt=2, then HG minimum dwell restarts.
        add(1, 0, 0, 0, P_HG);
        add(0, 1, 0, 7, P_HG);  add(0, 1, 0, 5, P_HA);  add(0, 1, 0, 3, P_R1);
        add(0, 1, 0, 16, P_SG); add(0, 1, 0, 3, P_SA);
        add(1, 0, 0, 0, P_HG);
        add(0, 1, 0, 7, P_HG);  add(0, 1, 0, 1, P_HA);

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                for (int k = 0; k < vecs[i].n; k++) begin
                    step(vecs[i].side, vecs[i].ped);
                    check_out($sformatf("vec%0d.%0d", i, k), vecs[i].ph);
                end
            end
        end

        // Randomized traffic against the reference model.
        do_reset();
        s_cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 11) == 0) s_cur = ~s_cur;
                p_now = ($urandom_range(0, 29) == 0);
                step(s_cur, p_now);
                model_step(s_cur, p_now);
                check_out($sformatf("rand%0d", i), 3'(m_ph));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
